// File: rtl/mem_port_arbiter.sv
// Two-requester (instruction fetch / data) arbiter for a single synchronous memory port.
// Optional ARB_DATA_PRIO_EN: data requester wins every tie instead of round-robin.
module mem_port_arbiter #(
  parameter int unsigned MEM_AW  = 12,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [63:0]       if_req_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [63:0]       d_req_addr,
  input  logic              d_req_we,
  input  logic [31:0]       d_req_wdata,
  input  logic [3:0]        d_req_wstrb,
  output logic              d_resp_valid,
  output logic [31:0]       d_resp_data,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {REQ_IF = 1'b0, REQ_D = 1'b1} req_t;

  state_t            state, state_nx;
  req_t              owner, last_grant, winner;
  logic [3:0]        cnt;
  logic [MEM_AW-1:0] addr_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       if_data_q, d_data_q;
  logic              handshake;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[63:MEM_AW+2], if_req_addr[1:0],
                              d_req_addr[63:MEM_AW+2], d_req_addr[1:0]};

  always_comb begin
    winner = REQ_IF;
    if (if_req_valid && d_req_valid) begin
`ifdef ARB_DATA_PRIO_EN
      winner = REQ_D;
`else
      winner = (last_grant == REQ_D) ? REQ_IF : REQ_D;
`endif
    end else if (d_req_valid) begin
      winner = REQ_D;
    end
  end

  // Ready is gated by reset so nothing is accepted while reset is held.
  assign if_req_ready = reset && (state == IDLE) && if_req_valid && (winner == REQ_IF);
  assign d_req_ready  = reset && (state == IDLE) && d_req_valid  && (winner == REQ_D);
  assign handshake    = if_req_ready || d_req_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (handshake) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_en        = (state == ISSUE);
  assign mem_we        = (state == ISSUE && we_q) ? wstrb_q : '0;
  assign mem_addr      = (state == ISSUE) ? addr_q : '0;
  assign mem_wdata     = (state == ISSUE) ? wdata_q : '0;
  assign if_resp_valid = (state == RESP) && (owner == REQ_IF);
  assign d_resp_valid  = (state == RESP) && (owner == REQ_D);
  assign if_resp_data  = if_data_q;
  assign d_resp_data   = d_data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= REQ_IF;
      last_grant <= REQ_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      if_data_q  <= '0;
      d_data_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && handshake) begin
        owner      <= winner;
        last_grant <= winner;
        if (winner == REQ_IF) begin
          addr_q  <= if_req_addr[MEM_AW+1:2];
          we_q    <= 1'b0;
          wdata_q <= '0;
          wstrb_q <= '0;
        end else begin
          addr_q  <= d_req_addr[MEM_AW+1:2];
          we_q    <= d_req_we;
          wdata_q <= d_req_wdata;
          wstrb_q <= d_req_wstrb;
        end
      end
      if (state == ISSUE) cnt <= 4'(MEM_LAT - 1);
      if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (owner == REQ_IF) begin
          if_data_q <= mem_rdata;
        end else begin
          d_data_q <= we_q ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner cases,
// random traffic against a transaction-level model; a second instance runs MEM_LAT=3.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic          if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0]   if_req_addr, d_req_addr;
  logic [31:0]   if_resp_data, d_resp_data, d_req_wdata, mem_wdata, mem_rdata;
  logic          d_req_valid, d_req_ready, d_req_we, d_resp_valid, mem_en;
  logic [3:0]    d_req_wstrb, mem_we;
  logic [AW-1:0] mem_addr;

  logic          if_req_valid3, if_req_ready3, if_resp_valid3;
  logic [63:0]   if_req_addr3, d_req_addr3;
  logic [31:0]   if_resp_data3, d_resp_data3, d_req_wdata3, mem_wdata3, mem_rdata3;
  logic          d_req_valid3, d_req_ready3, d_req_we3, d_resp_valid3, mem_en3;
  logic [3:0]    d_req_wstrb3, mem_we3;
  logic [AW-1:0] mem_addr3;

  mem_port_arbiter #(.MEM_AW(AW), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_AW(AW), .MEM_LAT(3)) dut3 (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid3), .if_req_ready(if_req_ready3), .if_req_addr(if_req_addr3),
    .if_resp_valid(if_resp_valid3), .if_resp_data(if_resp_data3),
    .d_req_valid(d_req_valid3), .d_req_ready(d_req_ready3), .d_req_addr(d_req_addr3),
    .d_req_we(d_req_we3), .d_req_wdata(d_req_wdata3), .d_req_wstrb(d_req_wstrb3),
    .d_resp_valid(d_resp_valid3), .d_resp_data(d_resp_data3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3)
  );

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 16) return 32'h0050_0093;
    return 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // Memory models: latency 1 for dut, 3-stage read pipe for dut3.
  logic        mem_load;
  logic [31:0] mem  [4096];
  logic [31:0] mem3 [4096];
  logic [31:0] rd1;
  logic [31:0] p3 [3];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
    end else if (mem_en) begin
      rd1 <= mem[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end
  assign mem_rdata = rd1;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 4096; i++) mem3[i] <= init_word(i);
    end else begin
      p3[0] <= mem_en3 ? mem3[mem_addr3] : 32'h0;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
      if (mem_en3)
        for (int b = 0; b < 4; b++)
          if (mem_we3[b]) mem3[mem_addr3][8*b +: 8] <= mem_wdata3[8*b +: 8];
    end
  end
  assign mem_rdata3 = p3[2];

  // Transaction-level reference state.
  logic [31:0] ref_mem [4096];
  int          model_last;
  logic [31:0] exp_if_data, exp_d_data;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=%h required=%h", name, act, exp);
  endtask

  task automatic clear_inputs();
    if_req_valid = 0; if_req_addr = '0; d_req_valid = 0; d_req_addr = '0;
    d_req_we = 0; d_req_wdata = '0; d_req_wstrb = '0;
  endtask

  task automatic model_reset();
    model_last  = 1;
    exp_if_data = '0;
    exp_d_data  = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1;
    model_reset();
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input bit iv, input logic [63:0] ia, input bit dv, input logic [63:0] da,
                         input bit dwe, input logic [31:0] dwd, input logic [3:0] dws,
                         input bit hold, output int got_owner, output logic [31:0] got_data);
    int          w;
    logic [11:0] wa;
    logic [31:0] old;
    logic [3:0]  exp_we;
    if_req_valid = iv; if_req_addr = ia; d_req_valid = dv; d_req_addr = da;
    d_req_we = dwe; d_req_wdata = dwd; d_req_wstrb = dws;
    if (iv && dv) begin
`ifdef ARB_DATA_PRIO_EN
      w = 1;
`else
      w = (model_last == 1) ? 0 : 1;
`endif
    end else begin
      w = dv ? 1 : 0;
    end
    model_last = w;
    wa     = (w == 1) ? da[13:2] : ia[13:2];
    old    = ref_mem[wa];
    exp_we = (w == 1 && dwe) ? dws : 4'b0;
    for (int b = 0; b < 4; b++)
      if (exp_we[b]) ref_mem[wa][8*b +: 8] = dwd[8*b +: 8];
    if (w == 1) exp_d_data = dwe ? 32'h0 : old;
    else        exp_if_data = old;

    @(negedge clk);
    chk("if_ready", if_req_ready, iv && w == 0);
    chk("d_ready", d_req_ready, dv && w == 1);
    chk("idle_quiet", {mem_en, if_resp_valid, d_resp_valid}, 0);
    @(posedge clk); #1;
    if (!hold) begin if_req_valid = 0; d_req_valid = 0; end
    @(negedge clk);
    chk("issue_mem_en", mem_en, 1);
    chk("issue_addr", mem_addr, wa);
    chk("issue_we", mem_we, exp_we);
    if (exp_we != 4'b0) chk("issue_wdata", mem_wdata, dwd);
    chk("issue_ready", {if_req_ready, d_req_ready, if_resp_valid, d_resp_valid}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wait_quiet", {mem_en, mem_we, if_resp_valid, d_resp_valid, if_req_ready, d_req_ready}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("resp_valid", {if_resp_valid, d_resp_valid}, (w == 1) ? 2'b01 : 2'b10);
    chk("if_resp_data", if_resp_data, exp_if_data);
    chk("d_resp_data", d_resp_data, exp_d_data);
    chk("resp_quiet", {mem_en, if_req_ready, d_req_ready}, 0);
    got_owner = d_resp_valid ? 1 : (if_resp_valid ? 0 : 2);
    got_data  = (w == 1) ? d_resp_data : if_resp_data;
    @(posedge clk); #1;
  endtask

  task automatic lat3_txn(input bit is_d, input logic [63:0] a, input logic [31:0] exp);
    int n = 0;
    int en_cnt = 0;
    if (is_d) begin d_req_valid3 = 1; d_req_addr3 = a; d_req_we3 = 0; end
    else begin if_req_valid3 = 1; if_req_addr3 = a; end
    @(negedge clk);
    chk("l3_ready", is_d ? d_req_ready3 : if_req_ready3, 1);
    @(posedge clk); #1;
    if_req_valid3 = 0; d_req_valid3 = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en3) en_cnt++;
      if (if_resp_valid3 || d_resp_valid3) begin n = k; break; end
      @(posedge clk); #1;
    end
    chk("l3_latency", n, 5);
    chk("l3_mem_en_cycles", en_cnt, 1);
    chk("l3_owner", {if_resp_valid3, d_resp_valid3}, is_d ? 2'b01 : 2'b10);
    chk("l3_data", is_d ? d_resp_data3 : if_resp_data3, exp);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          iv;
    logic [63:0] ia;
    bit          dv;
    logic [63:0] da;
    bit          we;
    logic [31:0] wd;
    logic [3:0]  ws;
    int          exp_owner;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [8];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int          o;
    logic [31:0] d;
    int          exp_own [4];

    tbl[0] = '{1'b1, 64'h40, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0, 0, 32'h0050_0093};
    tbl[1] = '{1'b0, 64'h0, 1'b1, 64'h84, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1, 32'h0};
    tbl[2] = '{1'b0, 64'h0, 1'b1, 64'h84, 1'b0, 32'h0, 4'h0, 1, 32'h1000_BEEF};
`ifdef ARB_DATA_PRIO_EN
    tbl[3] = '{1'b1, 64'h44, 1'b1, 64'h88, 1'b0, 32'h0, 4'h0, 1, 32'h1000_2222};
`else
    tbl[3] = '{1'b1, 64'h44, 1'b1, 64'h88, 1'b0, 32'h0, 4'h0, 0, 32'h1000_1111};
`endif
    tbl[4] = '{1'b1, 64'h44, 1'b1, 64'h88, 1'b0, 32'h0, 4'h0, 1, 32'h1000_2222};
    tbl[5] = '{1'b0, 64'h0, 1'b1, 64'hFFFF_0000_0000_408B, 1'b0, 32'h0, 4'h0, 1, 32'h1000_2222};
    tbl[6] = '{1'b0, 64'h0, 1'b1, 64'h3FFC, 1'b1, 32'h1234_5678, 4'b1111, 1, 32'h0};
    tbl[7] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0, 32'h0, 4'h0, 0, 32'h1234_5678};

    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    clear_inputs();
    if_req_valid3 = 0; if_req_addr3 = '0; d_req_valid3 = 0; d_req_addr3 = '0;
    d_req_we3 = 0; d_req_wdata3 = '0; d_req_wstrb3 = '0;
    model_reset();
    reset = 0;
    mem_load = 1;
    @(posedge clk); #1;
    mem_load = 0;
    @(negedge clk);
    chk("rst_ctrl", {if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_en, mem_we}, 0);
    chk("rst_bus", {mem_addr, mem_wdata}, 0);
    chk("rst_data", {if_resp_data, d_resp_data}, 0);
    chk("rst3_ctrl", {if_req_ready3, d_req_ready3, if_resp_valid3, d_resp_valid3, mem_en3, mem_we3}, 0);
    @(posedge clk); #1;
    reset = 1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].iv, tbl[i].ia, tbl[i].dv, tbl[i].da, tbl[i].we, tbl[i].wd, tbl[i].ws, 1'b0, o, d);
      chk($sformatf("tbl%0d_owner", i), o, tbl[i].exp_owner);
      chk($sformatf("tbl%0d_data", i), d, tbl[i].exp_data);
    end

    // Data request raised and withdrawn while an IF transaction is in flight.
    model_last  = 0;
    exp_if_data = ref_mem[12'h013];
    if_req_valid = 1; if_req_addr = 64'h4C;
    @(negedge clk);
    chk("wd_if_ready", if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 0; d_req_valid = 1; d_req_addr = 64'h90; d_req_we = 0;
    @(negedge clk);
    chk("wd_d_ready_busy", d_req_ready, 0);
    @(posedge clk); #1;
    d_req_valid = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("wd_resp", {if_resp_valid, d_resp_valid}, 2'b10);
    chk("wd_if_data", if_resp_data, exp_if_data);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wd_idle_quiet", {mem_en, if_resp_valid, d_resp_valid}, 0);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 40; i++) begin
      bit          iv, dv, we, hold;
      logic [63:0] ia, da;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      if (!iv && !dv) iv = 1;
      ia = {$urandom(), $urandom()};
      da = {$urandom(), $urandom()};
      we = 1'($urandom_range(0, 1));
      hold = 1'($urandom_range(0, 1));
      run_txn(iv, ia, dv, da, we, $urandom(), 4'($urandom_range(0, 15)), hold, o, d);
      clear_inputs();
    end

    // Continuous contention straight after reset.
    do_reset();
`ifdef ARB_DATA_PRIO_EN
    exp_own = '{1, 1, 1, 1};
`else
    exp_own = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 64'h100 + 64'(4 * i), 1'b1, 64'h200 + 64'(4 * i), 1'b0, 32'h0, 4'h0, 1'b1, o, d);
      chk($sformatf("cont%0d_owner", i), o, exp_own[i]);
    end
    clear_inputs();

    // Reset asserted while the transaction sits in WAIT.
    if_req_valid = 1; if_req_addr = 64'h48;
    @(negedge clk);
    chk("rm_if_ready", if_req_ready, 1);
    @(posedge clk); #1;
    if_req_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    model_reset();
    @(negedge clk);
    chk("rm_ctrl", {if_req_ready, d_req_ready, if_resp_valid, d_resp_valid, mem_en, mem_we}, 0);
    chk("rm_bus", {mem_addr, mem_wdata}, 0);
    chk("rm_data", {if_resp_data, d_resp_data}, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rm_no_resp", {if_resp_valid, d_resp_valid, mem_en}, 0);
      @(posedge clk); #1;
    end
    run_txn(1'b1, 64'h40, 1'b1, 64'h88, 1'b0, 32'h0, 4'h0, 1'b0, o, d);
`ifdef ARB_DATA_PRIO_EN
    chk("rm_tie_owner", o, 1);
`else
    chk("rm_tie_owner", o, 0);
    chk("rm_tie_data", d, 32'h0050_0093);
`endif

    lat3_txn(1'b0, 64'h40, 32'h0050_0093);
    lat3_txn(1'b1, 64'h88, 32'h1000_2222);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single synchronous memory port between two requesters: instruction fetch (IF) and data load/store (D).
- Sits between the multicycle core's FETCH_INSTR and memory-access stages and the word-addressed memory array.
- Arbitrates, issues one transaction at a time, times the fixed memory read latency and returns a one-cycle response pulse to the owner.
- Round-robin on simultaneous requests.

Parameters:
MEM_AW, 12, memory word-address width (word index = byte address[MEM_AW+1:2])
MEM_LAT, 1, memory read latency in cycles from mem_en to valid mem_rdata; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  64  fetch byte address
if_resp_valid  out  1  fetch data valid, one-cycle pulse
if_resp_data  out  32  fetched instruction word
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  64  data byte address
d_req_we  in  1  1 = store, 0 = load
d_req_wdata  in  32  store data
d_req_wstrb  in  4  store byte enables
d_resp_valid  out  1  load data / store ack, one-cycle pulse
d_resp_data  out  32  load data; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  4  byte write enables
mem_addr  out  MEM_AW  word address
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low.
- Reset: state=IDLE; cnt=0; owner=IF; last_grant=D.
- Reset outputs: all *_ready, *_resp_valid, mem_en and mem_we = 0; resp_data and mem_addr/mem_wdata = 0.
- Reset mid-transaction: the transaction is dropped and no response is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner selection is combinational.
  - Only IF valid -> IF wins; only D valid -> D wins.
  - Both valid -> the requester that is not last_grant wins.
  - Only the winner's ready=1; the loser's ready=0.
  - A handshake (valid && ready) latches owner, word address addr[MEM_AW+1:2], we, wdata and wstrb. IF is always a read.
  - On handshake: last_grant <= winner; next state ISSUE.
  - addr[1:0] and addr bits above MEM_AW+1 are ignored.
- ISSUE:
  - mem_en=1; mem_addr and mem_wdata driven from the latched values.
  - mem_we = wstrb if we, else 0.
  - cnt <= MEM_LAT-1; next state WAIT.
- WAIT:
  - mem_en=0 and mem_we=0.
  - cnt==0 -> capture mem_rdata into the owner's resp_data (0 if store); next state RESP.
  - Otherwise cnt decrements.
- RESP: the owner's resp_valid=1 for exactly one cycle; next state IDLE.
- Latency: handshake at cycle T -> mem_en at T+1 -> resp_valid at T+2+MEM_LAT.
- Throughput: one transaction per 3+MEM_LAT cycles. Ready is never asserted outside IDLE.
- resp_data holds its value until the next response to the same requester.
- Requester obligations: hold valid/addr/data stable until ready. Inputs are don't-care after the handshake.
- A requester that drops valid before ready: no transaction, no state change.
- *_resp_valid is never asserted for a requester that does not own the transaction. IF and D responses are never simultaneous.

Optional Feature:
- Macro: ARB_DATA_PRIO_EN.
- Defined: fixed priority, D always wins when both request. last_grant is still updated but ignored, so IF can starve under back-to-back D traffic.
- Undefined: round-robin as specified above.

Test Plan:
- Basic fetch: MEM_LAT=1, mem[0x10]=0x00500093, IF request at byte addr 0x40 at cycle T -> if_req_ready=1 at T; mem_en=1, mem_addr=0x10 at T+1; if_resp_valid=1, if_resp_data=0x00500093 at T+3 only; d_resp_valid never asserted.
- Store then load: D store to addr 0x84, wdata=0xDEADBEEF, wstrb=0b0011 -> mem_we=0b0011 for one cycle, d_resp_data=0. Then D load from 0x84 -> d_resp_data=0x????BEEF, with upper bytes equal to their prior content.
- Contention: IF and D both held valid continuously after reset -> grants alternate IF, D, IF, D (IF first, since last_grant resets to D); each response goes to the correct requester. With ARB_DATA_PRIO_EN defined -> D granted every time, IF never granted.
- Latency sweep: MEM_LAT=3 -> resp_valid exactly 5 cycles after the handshake; mem_en high for exactly 1 cycle per transaction.
- Reset mid-op: reset=0 during WAIT -> next cycle state IDLE, no resp_valid, all outputs 0. After release, a new IF request completes normally and IF wins a tie.
- Withdrawn request: D valid for one cycle while busy, dropped before IDLE -> no mem_en, no d_resp_valid.
